// File: rtl/alu_md_unit.sv
// alu_md_unit: integer ALU with an iterative multiply/divide path.
//
// States:
//   IDLE | waiting for a request, in_ready = 1
//   CALC | iterating shift-add multiply or restoring divide, WIDTH cycles
//   DONE | result held until the consumer takes it (out_valid = 1)
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  request handshake
//   aluop, funct3,
//   funct7b5, opb5       operation select (captured at accept only)
//   srca, srcb           operands (captured at accept only)
//   out_valid / out_ready result handshake
//   result, zero, illegal  result word, result == 0, unsupported op flag
module alu_md_unit #(
    parameter int WIDTH       = 32,
    parameter int ITER_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             opb5,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(ITER_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(ITER_CYCLES - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;    // product accumulator / partial remainder
    logic [WIDTH-1:0] op_a_q;   // multiplicand (shifts left) / dividend->quotient
    logic [WIDTH-1:0] op_b_q;   // multiplier (shifts right) / divisor
    logic             mul_q;
    logic             rem_q;
    logic             neg_q;
    logic [WIDTH-1:0] result_q;
    logic             illegal_q;

    // Accept-time decode
    logic [WIDTH-1:0] fast_res;
    logic             fast_ill;
    logic             go_calc;
    logic             calc_mul;
    logic             calc_rem;
    logic             calc_neg;
    logic [WIDTH-1:0] calc_a;
    logic [WIDTH-1:0] calc_b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_by_zero;
    logic             sdiv_ovf;

    always_comb begin
        fast_res    = '0;
        fast_ill    = 1'b0;
        go_calc     = 1'b0;
        calc_mul    = 1'b0;
        calc_rem    = funct3[1];
        calc_neg    = 1'b0;
        calc_a      = srca;
        calc_b      = srcb;
        shamt       = srcb[SHW-1:0];
        abs_a       = srca[WIDTH-1] ? -srca : srca;
        abs_b       = srcb[WIDTH-1] ? -srcb : srcb;
        div_by_zero = (srcb == '0);
        sdiv_ovf    = (srca == MOST_NEG) && (srcb == '1);
        case (aluop)
            2'b00: fast_res = srca + srcb;
            2'b01: fast_res = srca - srcb;
            2'b10: begin
                case (funct3)
                    3'b000: fast_res = (funct7b5 && opb5) ? srca - srcb : srca + srcb;
                    3'b001: fast_res = srca << shamt;
                    3'b010: fast_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
                    3'b011: fast_res = {{(WIDTH-1){1'b0}}, srca < srcb};
                    3'b100: fast_res = srca ^ srcb;
                    3'b101: fast_res = funct7b5 ? $unsigned($signed(srca) >>> shamt)
                                                : srca >> shamt;
                    3'b110: fast_res = srca | srcb;
                    default: fast_res = srca & srcb;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000: begin
                        go_calc  = 1'b1;
                        calc_mul = 1'b1;
                    end
                    3'b100, 3'b110: begin
                        // div / rem: degenerate cases resolve without iterating
                        if (div_by_zero) begin
                            fast_res = funct3[1] ? srca : '1;
                        end else if (sdiv_ovf) begin
                            fast_res = funct3[1] ? '0 : srca;
                        end else begin
                            go_calc  = 1'b1;
                            calc_a   = abs_a;
                            calc_b   = abs_b;
                            calc_neg = funct3[1] ? srca[WIDTH-1]
                                                 : srca[WIDTH-1] ^ srcb[WIDTH-1];
                        end
                    end
                    3'b101, 3'b111: begin
                        if (div_by_zero) begin
                            fast_res = funct3[1] ? srca : '1;
                        end else begin
                            go_calc = 1'b1;
                        end
                    end
                    default: fast_ill = 1'b1;
                endcase
            end
        endcase
    end

    // One iteration step of each algorithm
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] result_d;

    always_comb begin
        mul_acc   = op_b_q[0] ? acc_q + op_a_q : acc_q;
        div_shift = {acc_q, op_a_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, op_b_q});
        // when the divisor fits, the difference is below the divisor so WIDTH bits suffice
        rem_nx    = div_fits ? div_shift[WIDTH-1:0] - op_b_q : div_shift[WIDTH-1:0];
        quo_nx    = {op_a_q[WIDTH-2:0], div_fits};
        div_mag   = rem_q ? rem_nx : quo_nx;
        result_d  = mul_q ? mul_acc : (neg_q ? -div_mag : div_mag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mul_q     <= 1'b0;
            rem_q     <= 1'b0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (go_calc) begin
                            state_q <= CALC;
                            cnt_q   <= CNT_LOAD;
                            acc_q   <= '0;
                            op_a_q  <= calc_a;
                            op_b_q  <= calc_b;
                            mul_q   <= calc_mul;
                            rem_q   <= calc_rem;
                            neg_q   <= calc_neg;
                        end else begin
                            state_q   <= DONE;
                            result_q  <= fast_res;
                            illegal_q <= fast_ill;
                        end
                    end
                end
                CALC: begin
                    if (mul_q) begin
                        acc_q  <= mul_acc;
                        op_a_q <= op_a_q << 1;
                        op_b_q <= op_b_q >> 1;
                    end else begin
                        acc_q  <= rem_nx;
                        op_a_q <= quo_nx;
                    end
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        result_q  <= result_d;
                        illegal_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_md_unit.sv
module tb_alu_md_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   aluop;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic         opb5;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    always #5 clk = ~clk;

    alu_md_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .funct7b5(funct7b5), .opb5(opb5),
        .srca(srca), .srcb(srcb), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           lat;
        int           acc;
    } exp_t;

    exp_t scb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   or_mode = 0;   // 0: out_ready=1, 1: random, 2: driven by main
    bit   mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model straight from the instruction semantics
    function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                  input logic f7, input logic o5,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ill, output int lat);
        int sa;
        int sbv;
        logic [4:0] sh;
        sa  = a;
        sbv = b;
        sh  = b[4:0];
        r   = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: case (f3)
                3'd0: r = (f7 && o5) ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = (sa < sbv) ? 1 : 0;
                3'd3: r = (a < b) ? 1 : 0;
                3'd4: r = a ^ b;
                3'd5: r = f7 ? W'(sa >>> sh) : a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
            default: case (f3)
                3'd0: begin r = W'(a * b); lat = W + 1; end
                3'd4: begin
                    if (b == 0) r = '1;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                    else begin r = sa / sbv; lat = W + 1; end
                end
                3'd5: begin
                    if (b == 0) r = '1;
                    else begin r = a / b; lat = W + 1; end
                end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                    else begin r = sa % sbv; lat = W + 1; end
                end
                3'd7: begin
                    if (b == 0) r = a;
                    else begin r = a % b; lat = W + 1; end
                end
                default: ill = 1'b1;
            endcase
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic o5, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   t;
        t = 0;
        while (in_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, expected 1", in_ready, t);
            return;
        end
        aluop    = op;
        funct3   = f3;
        funct7b5 = f7;
        opb5     = o5;
        srca     = a;
        srcb     = b;
        in_valid = 1'b1;
        model(op, f3, f7, o5, a, b, e.res, e.ill, e.lat);
        e.acc = cyc;
        scb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        aluop    = 2'($urandom);
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
        opb5     = 1'($urandom);
        srca     = $urandom;
        srcb     = $urandom;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 20));
            5: return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (or_mode == 0) out_ready = 1'b1;
            else if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard checker
    initial begin
        bit           pv;
        bit           phs;
        logic [W-1:0] pres;
        logic         pill;
        int           first;
        exp_t         e;
        pv = 1'b0; phs = 1'b0; pres = '0; pill = 1'b0; first = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                pv  = 1'b0;
                phs = 1'b0;
                continue;
            end
            if (phs) begin
                chk("in_ready_after_take", W'(in_ready), 1);
                chk("out_valid_after_take", W'(out_valid), 0);
            end
            if (out_valid === 1'b1) begin
                chk("in_ready_low_in_done", W'(in_ready), 0);
                if (!pv) first = cyc;
                else begin
                    chk("hold_result", result, pres);
                    chk("hold_illegal", W'(illegal), W'(pill));
                end
                if (out_ready === 1'b1) begin
                    if (scb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got result %h, expected no output", result);
                    end else begin
                        e = scb.pop_front();
                        chk("result", result, e.res);
                        chk("zero", W'(zero), W'(e.res == '0));
                        chk("illegal", W'(illegal), W'(e.ill));
                        chk("latency", W'(first - e.acc), W'(e.lat));
                    end
                end
            end
            phs  = (out_valid === 1'b1) && (out_ready === 1'b1);
            pv   = (out_valid === 1'b1) && !phs;
            pres = result;
            pill = illegal;
        end
    end

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (scb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d results outstanding, expected 0", nm, scb.size());
            scb.delete();
        end
    endtask

    initial begin
        int t;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; funct3 = '0; funct7b5 = 1'b0; opb5 = 1'b0; srca = '0; srcb = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_zero", W'(zero), 1);
        chk("rst_illegal", W'(illegal), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        send(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd7);
        send(2'b11, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3);
        chk("busy_in_ready", W'(in_ready), 0);
        repeat (31) begin
            @(negedge clk);
            chk("busy_in_ready", W'(in_ready), 0);
        end
        send(2'b11, 3'b100, 1'b0, 1'b1, -32'sd7, 32'd2);
        send(2'b11, 3'b110, 1'b0, 1'b1, -32'sd7, 32'd2);
        send(2'b11, 3'b101, 1'b0, 1'b1, 32'h1234, 32'd0);
        send(2'b11, 3'b111, 1'b0, 1'b1, 32'h1234, 32'd0);
        send(2'b11, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        send(2'b11, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        send(2'b11, 3'b010, 1'b0, 1'b1, 32'd9, 32'd9);
        send(2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FF24);
        drain("drain_directed");

        // Backpressure: hold DONE for five cycles
        or_mode   = 2;
        out_ready = 1'b0;
        send(2'b01, 3'b000, 1'b0, 1'b0, 32'd10, 32'd3);
        t = 0;
        while (out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_reached", W'(out_valid), 1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        or_mode = 0;
        drain("drain_backpressure");

        or_mode = 1;
        repeat (300) begin
            send(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), pick(), pick());
        end
        drain("drain_random");
        or_mode = 0;
        @(negedge clk);

        // Reset in the middle of a divu
        send(2'b11, 3'b101, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        scb.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", W'(in_ready), 1);
        chk("abort_out_valid", W'(out_valid), 0);
        chk("abort_result", result, 0);
        chk("abort_zero", W'(zero), 1);
        chk("abort_illegal", W'(illegal), 0);
        repeat (60) @(negedge clk);
        chk("abort_no_stale", W'(out_valid), 0);

        send(2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        drain("drain_final");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_md_unit.md
ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 SHALL have parameter ITER_CYCLES, default WIDTH, cycles spent in CALC for multiply/divide (fixed to WIDTH in this generation).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port aluop  input  2  00 add, 01 sub, 10 funct3-decoded integer op, 11 funct3-decoded M-extension op.
REQ-008 SHALL have port funct3  input  3  instruction funct3.
REQ-009 SHALL have port funct7b5  input  1  instruction bit 30.
REQ-010 SHALL have port opb5  input  1  opcode bit 5 (1 = R-type).
REQ-011 SHALL have port srca  input  WIDTH  operand A.
REQ-012 SHALL have port srcb  input  WIDTH  operand B.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer takes result.
REQ-015 SHALL have port result  output  WIDTH  operation result.
REQ-016 SHALL have port zero  output  1  result == 0.
REQ-017 SHALL have port illegal  output  1  request decoded to unsupported op; valid with out_valid.

Function
REQ-018 SHALL implement states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-019 SHALL accept a request when in_valid & in_ready, capturing aluop, funct3, funct7b5, opb5, srca, srcb.
REQ-020 SHALL decode aluop=10: funct3 000 add, or sub when funct7b5 & opb5; 001 sll; 010 slt (signed); 011 sltu; 100 xor; 101 srl, or sra when funct7b5; 110 or; 111 and.
REQ-021 SHALL take shift amount as srcb[log2(WIDTH)-1:0], upper bits ignored.
REQ-022 SHALL decode aluop=11: funct3 000 mul (low WIDTH bits), 100 div, 101 divu, 110 rem, 111 remu; 001/010/011 illegal.
REQ-023 Single-cycle ops (aluop 00/01/10), illegal ops, divide-by-zero and signed overflow SHALL go IDLE -> DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-024 mul/div/rem SHALL go IDLE -> CALC, iterate exactly WIDTH cycles (shift-add multiply, restoring divide on magnitudes), then CALC -> DONE; out_valid asserts WIDTH+1 cycles after acceptance.
REQ-025 Signed div/rem SHALL use magnitudes and fix signs at completion: quotient negative iff operand signs differ, remainder takes sign of dividend.
REQ-026 Divide by zero SHALL give quotient all ones and remainder = srca, signed or unsigned.
REQ-027 Signed overflow (srca = most-negative, srcb = -1) SHALL give quotient = srca, remainder 0.
REQ-028 Illegal op SHALL give result 0, illegal = 1; all other ops illegal = 0.
REQ-029 In DONE, result, zero and illegal SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-030 DONE -> IDLE SHALL occur on out_valid & out_ready; no new request accepted in that same cycle (in_ready rises next cycle).
REQ-031 Inputs other than in_valid and out_ready SHALL be ignored outside the accept cycle.
REQ-032 Arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag.

Reset
REQ-033 reset high at a rising edge SHALL force IDLE regardless of state, aborting any CALC operation with no result produced.
REQ-034 After reset: in_ready = 1, out_valid = 0, result = 0, zero = 1, illegal = 0, iteration counter = 0.

Verification
REQ-035 aluop=10, funct3=000, funct7b5=1, opb5=1, srca=5, srcb=7, out_ready=1 -> out_valid one cycle later, result=0xFFFFFFFE, zero=0.
REQ-036 aluop=11, funct3=000, srca=0xFFFFFFFF, srcb=3 -> out_valid 33 cycles after accept, result=0xFFFFFFFD; in_ready=0 throughout.
REQ-037 aluop=11, funct3=100, srca=-7, srcb=2 -> result=-3 (0xFFFFFFFD); funct3=110 same operands -> result=-1.
REQ-038 divu srcb=0, srca=0x1234 -> result=0xFFFFFFFF at latency 1; remu -> 0x1234; div 0x80000000 / -1 -> 0x80000000.
REQ-039 out_ready=0 for 5 cycles in DONE -> result, illegal, out_valid stable; in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-040 reset asserted at CALC cycle 10 of divu -> next cycle in_ready=1, out_valid=0, result=0; no stale result later.
